// File: rtl/stack_mem_ctrl_if.sv
// Request, response and word-memory signals of the stack/memory sequencer.
interface stack_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Requester / memory side
    modport master (
        output req_valid, req_op, req_addr, req_data, mem_rdata,
        input  req_ready, mem_addr, mem_wdata, mem_write, rsp_valid, rsp_data, rsp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_addr, req_data, mem_rdata,
        output req_ready, mem_addr, mem_wdata, mem_write, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Memory-stage sequencer: load/store/push/pop, owns the stack pointer,
// one response per accepted request.
module stack_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SP_RESET = 16'hFFFE,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 16'h8000,
    parameter int                READ_LAT = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    stack_mem_ctrl_if.slave     bus,
    input  logic                sp_we,
    input  logic [ADDR_W-1:0]   sp_wdata,
    input  logic                fault_clr,
    output logic [ADDR_W-1:0]   sp,
    output logic                stack_fault
);
    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_e;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO        = ADDR_W'(2);

    state_e            state, state_d;
    op_e               op_q, req_op;
    logic [ADDR_W-1:0] addr_q, sp_q, sp_m2;
    logic [DATA_W-1:0] data_q, rsp_data_q;
    logic [1:0]        cnt_q;
    logic              fault_q, fault_flag_q;
    logic              ready, accept, req_fault;

    assign req_op = op_e'(bus.req_op);
    assign ready  = (state == IDLE) && !sp_we;
    assign accept = bus.req_valid && ready;
    assign sp_m2  = sp_q - TWO;

    // Stack bounds check for the request being offered this cycle
    always_comb begin
        req_fault = 1'b0;
        if (req_op == OP_PUSH)
            req_fault = (sp_q < TWO) || (sp_m2 < SP_LIMIT);
        else if (req_op == OP_POP)
            req_fault = (sp_q >= SP_RESET);
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault)
                        state_d = RESP;
                    else if (req_op == OP_STORE || req_op == OP_PUSH)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            WR:   state_d = RESP;
            RD:   if (cnt_q == 2'd0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Request capture, stack pointer, read counter and response data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_LOAD;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            sp_q       <= SP_RESET;
            rsp_data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        data_q  <= bus.req_data;
                        fault_q <= req_fault;
                        cnt_q   <= 2'(READ_LAT);
                        unique case (req_op)
                            OP_PUSH: addr_q <= sp_m2 & ALIGN_MASK;
                            OP_POP:  addr_q <= sp_q & ALIGN_MASK;
                            default: addr_q <= bus.req_addr & ALIGN_MASK;
                        endcase
                        if (req_fault)
                            rsp_data_q <= '0;
                    end else if (sp_we) begin
                        sp_q <= sp_wdata & ALIGN_MASK;
                    end
                end
                WR: begin
                    rsp_data_q <= '0;
                    // addr_q already holds sp-2 for a push
                    if (op_q == OP_PUSH)
                        sp_q <= addr_q;
                end
                RD: begin
                    if (cnt_q == 2'd0) begin
                        rsp_data_q <= bus.mem_rdata;
                        if (op_q == OP_POP)
                            sp_q <= sp_q + TWO;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky fault flag; a new fault beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fault_flag_q <= 1'b0;
        else if (accept && req_fault)
            fault_flag_q <= 1'b1;
        else if (fault_clr)
            fault_flag_q <= 1'b0;
    end

    assign bus.req_ready = ready;
    assign bus.mem_write = (state == WR);
    assign bus.mem_addr  = (state == WR || state == RD) ? addr_q : '0;
    assign bus.mem_wdata = (state == WR) ? data_q : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) && fault_q;
    assign bus.rsp_data  = rsp_data_q;
    assign sp            = sp_q;
    assign stack_fault   = fault_flag_q;
endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl with a 1-cycle-latency word memory model.
module tb_stack_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sp_we = 1'b0;
    logic [15:0] sp_wdata = '0;
    logic        fault_clr = 1'b0;
    logic [15:0] sp;
    logic        stack_fault;

    int n_tests = 0;
    int n_fail  = 0;

    int          wr_cnt = 0;
    int          acc_cnt = 0;
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;
    logic [15:0] last_raddr = '0;
    logic [15:0] mem [0:32767];

    stack_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    stack_mem_ctrl #(
        .DATA_W(16), .ADDR_W(16), .SP_RESET(16'hFFFE), .SP_LIMIT(16'h8000), .READ_LAT(1)
    ) dut (
        .clock(clk), .reset_n(reset_n), .bus(bus), .sp_we(sp_we), .sp_wdata(sp_wdata),
        .fault_clr(fault_clr), .sp(sp), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    // Word memory: write on strobe, read data one cycle after address
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[15:1]];
    end

    // Memory access monitor
    always @(negedge clk) begin
        if (bus.mem_write) begin
            wr_cnt++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
        end else if (bus.mem_addr != 16'h0) begin
            last_raddr = bus.mem_addr;
        end
        if (bus.mem_write || bus.mem_addr != 16'h0) acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for its response; lat counts cycles from accept edge
    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                          output logic [15:0] rdata, output logic err, output int lat);
        int w;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        fault_clr     = 1'b0;
        lat = 0; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat   = k;
                rdata = bus.rsp_data;
                err   = bus.rsp_err;
                break;
            end
        end
    endtask

    task automatic set_sp(input logic [15:0] val, input logic with_req);
        @(negedge clk);
        sp_we    = 1'b1;
        sp_wdata = val;
        bus.req_valid = with_req;
        bus.req_op    = 2'b00;
        bus.req_addr  = 16'h0020;
        #1;
        check_eq("spwe_ready_low", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        sp_we = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat, w0, a0, rsp_seen;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_sp", {16'b0, sp}, 32'hFFFE);
        check_eq("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
        check_eq("rst_fault", {31'b0, stack_fault}, 32'd0);
        check_eq("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        check_eq("rst_mem_addr", {16'b0, bus.mem_addr}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // T1 store
        w0 = wr_cnt;
        do_req(2'b01, 16'h0010, 16'hBEEF, rd, er, lat);
        check_eq("t1_lat", lat, 32'd2);
        check_eq("t1_err", {31'b0, er}, 32'd0);
        check_eq("t1_data", {16'b0, rd}, 32'h0);
        check_eq("t1_wr_cnt", wr_cnt - w0, 32'd1);
        check_eq("t1_waddr", {16'b0, last_waddr}, 32'h0010);
        check_eq("t1_wdata", {16'b0, last_wdata}, 32'hBEEF);

        // T2 load, unaligned address
        do_req(2'b00, 16'h0011, 16'h0000, rd, er, lat);
        check_eq("t2_lat", lat, 32'd3);
        check_eq("t2_data", {16'b0, rd}, 32'hBEEF);
        check_eq("t2_raddr", {16'b0, last_raddr}, 32'h0010);

        // T3 push/push/pop/pop
        do_req(2'b10, 16'h0, 16'h1111, rd, er, lat);
        check_eq("t3_push1_lat", lat, 32'd2);
        check_eq("t3_push1_waddr", {16'b0, last_waddr}, 32'hFFFC);
        check_eq("t3_push1_sp", {16'b0, sp}, 32'hFFFC);
        do_req(2'b10, 16'h0, 16'h2222, rd, er, lat);
        check_eq("t3_push2_waddr", {16'b0, last_waddr}, 32'hFFFA);
        check_eq("t3_push2_wdata", {16'b0, last_wdata}, 32'h2222);
        check_eq("t3_push2_sp", {16'b0, sp}, 32'hFFFA);
        do_req(2'b11, 16'h0, 16'h0, rd, er, lat);
        check_eq("t3_pop1_lat", lat, 32'd3);
        check_eq("t3_pop1_data", {16'b0, rd}, 32'h2222);
        check_eq("t3_pop1_sp", {16'b0, sp}, 32'hFFFC);
        do_req(2'b11, 16'h0, 16'h0, rd, er, lat);
        check_eq("t3_pop2_data", {16'b0, rd}, 32'h1111);
        check_eq("t3_pop2_raddr", {16'b0, last_raddr}, 32'hFFFC);
        check_eq("t3_pop2_sp", {16'b0, sp}, 32'hFFFE);

        // T4 underflow
        a0 = acc_cnt;
        do_req(2'b11, 16'h0, 16'h0, rd, er, lat);
        check_eq("t4_lat", lat, 32'd1);
        check_eq("t4_err", {31'b0, er}, 32'd1);
        check_eq("t4_data", {16'b0, rd}, 32'h0);
        check_eq("t4_fault", {31'b0, stack_fault}, 32'd1);
        check_eq("t4_no_access", acc_cnt - a0, 32'd0);
        check_eq("t4_sp", {16'b0, sp}, 32'hFFFE);
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        check_eq("t4_clr", {31'b0, stack_fault}, 32'd0);
        // set beats clear on the same edge
        @(negedge clk);
        fault_clr = 1'b1;
        do_req(2'b11, 16'h0, 16'h0, rd, er, lat);
        check_eq("t4_set_wins", {31'b0, stack_fault}, 32'd1);

        // T5 sp_we and push boundary
        set_sp(16'h8003, 1'b0);
        check_eq("t5_sp_aligned", {16'b0, sp}, 32'h8002);
        do_req(2'b10, 16'h0, 16'h5555, rd, er, lat);
        check_eq("t5_limit_push_err", {31'b0, er}, 32'd0);
        check_eq("t5_limit_push_waddr", {16'b0, last_waddr}, 32'h8000);
        check_eq("t5_limit_push_sp", {16'b0, sp}, 32'h8000);
        a0 = acc_cnt;
        do_req(2'b10, 16'h0, 16'h6666, rd, er, lat);
        check_eq("t5_ovf_err", {31'b0, er}, 32'd1);
        check_eq("t5_ovf_lat", lat, 32'd1);
        check_eq("t5_ovf_sp", {16'b0, sp}, 32'h8000);
        check_eq("t5_ovf_no_access", acc_cnt - a0, 32'd0);
        a0 = acc_cnt;
        set_sp(16'h9000, 1'b1);
        check_eq("t5_spwe_req_sp", {16'b0, sp}, 32'h9000);
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        check_eq("t5_spwe_req_ignored", rsp_seen, 32'd0);
        check_eq("t5_spwe_no_access", acc_cnt - a0, 32'd0);

        // T6 reset during RD of a pop
        set_sp(16'hFFFC, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_in_rd", {16'b0, bus.mem_addr}, 32'hFFFC);
        reset_n = 1'b0;
        #1;
        check_eq("t6_mem_addr", {16'b0, bus.mem_addr}, 32'h0);
        check_eq("t6_sp", {16'b0, sp}, 32'hFFFE);
        check_eq("t6_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check_eq("t6_fault", {31'b0, stack_fault}, 32'd0);
        check_eq("t6_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        check_eq("t6_no_rsp", rsp_seen, 32'd0);
        check_eq("t6_ready", {31'b0, bus.req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
